// File: rtl/fir_interp.sv
// fir_interp: polyphase interpolating FIR for the FM receive chain.
// Pops one sample from an upstream FIFO, then produces INTERP filtered
// outputs (one per polyphase branch) into a downstream FIFO. Each output
// takes M = TAPS/INTERP multiply-accumulate cycles, one MAC per clock.
//
// Ports:
//   clock      - sole clock, rising edge
//   reset      - synchronous, active-high
//   x_in       - signed input sample at the input FIFO head
//   x_rd_en    - combinational pop strobe to the input FIFO
//   x_empty    - input FIFO empty
//   y_out      - registered signed output sample
//   y_out_full - output FIFO full
//   y_wr_en    - registered push strobe to the output FIFO
module fir_interp #(
    parameter int DATA_WIDTH = 32,
    parameter int TAPS       = 32,
    parameter int INTERP     = 4,
    parameter int BITS       = 10,
    parameter logic [0:TAPS-1][DATA_WIDTH-1:0] COEFF =
        {{4{DATA_WIDTH'(32'h00000400)}}, {(TAPS-4)*DATA_WIDTH{1'b0}}}
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] x_in,
    output logic                  x_rd_en,
    input  logic                  x_empty,
    output logic [DATA_WIDTH-1:0] y_out,
    input  logic                  y_out_full,
    output logic                  y_wr_en
);

    localparam int M  = TAPS / INTERP;
    localparam int KW = (M > 1) ? $clog2(M) : 1;
    localparam int PW = (INTERP > 1) ? $clog2(INTERP) : 1;
    localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;

    typedef enum logic [1:0] {S_READ, S_MAC, S_WRITE} state_t;
    typedef logic signed [2*DATA_WIDTH-1:0] wide_t;

    state_t                        state_q, state_d;
    logic signed [DATA_WIDTH-1:0]  x_q [M];
    logic signed [DATA_WIDTH-1:0]  x_d [M];
    logic [DATA_WIDTH-1:0]         sum_q, sum_d;
    logic [PW-1:0]                 phase_q, phase_d;
    logic [KW-1:0]                 k_q, k_d;
    logic [DATA_WIDTH-1:0]         y_out_q, y_out_d;
    logic                          y_wr_en_q, y_wr_en_d;

    logic [IW-1:0]                 coeff_idx;
    logic [DATA_WIDTH-1:0]         coef;
    logic signed [DATA_WIDTH-1:0]  x_k;
    logic [DATA_WIDTH-1:0]         mac_term;

    // Polyphase branch p uses taps p, p+INTERP, p+2*INTERP, ...
    assign coeff_idx = IW'(k_q) * IW'(INTERP) + IW'(phase_q);
    assign coef      = COEFF[coeff_idx];
    assign x_k       = x_q[k_q];
    // Full-width signed product, arithmetic shift (floor), then truncate.
    assign mac_term  = DATA_WIDTH'((wide_t'($signed(coef)) * wide_t'(x_k)) >>> BITS);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        sum_d     = sum_q;
        phase_d   = phase_q;
        k_d       = k_q;
        y_out_d   = y_out_q;
        y_wr_en_d = 1'b0;
        x_rd_en   = 1'b0;

        case (state_q)
            S_READ: begin
                if (!x_empty) begin
                    x_rd_en = 1'b1;
                    x_d[0]  = x_in;
                    for (int unsigned i = 1; i < M; i++) begin
                        x_d[i] = x_q[i-1];
                    end
                    phase_d = '0;
                    k_d     = '0;
                    sum_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                sum_d = sum_q + mac_term;
                k_d   = k_q + KW'(1);
                if (k_q == KW'(M-1)) begin
                    k_d     = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!y_out_full) begin
                    y_out_d   = sum_q;
                    y_wr_en_d = 1'b1;
                    if (phase_q == PW'(INTERP-1)) begin
                        state_d = S_READ;
                    end else begin
                        phase_d = phase_q + PW'(1);
                        k_d     = '0;
                        sum_d   = '0;
                        state_d = S_MAC;
                    end
                end
            end
            default: state_d = S_READ;
        endcase

        // No pop while reset is held, even though state_q may still be S_READ.
        if (reset) begin
            x_rd_en = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_READ;
            for (int unsigned i = 0; i < M; i++) begin
                x_q[i] <= '0;
            end
            sum_q     <= '0;
            phase_q   <= '0;
            k_q       <= '0;
            y_out_q   <= '0;
            y_wr_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            sum_q     <= sum_d;
            phase_q   <= phase_d;
            k_q       <= k_d;
            y_out_q   <= y_out_d;
            y_wr_en_q <= y_wr_en_d;
        end
    end

    assign y_out   = y_out_q;
    assign y_wr_en = y_wr_en_q;

endmodule

// File: tb/tb_fir_interp.sv
// tb_fir_interp: directed bench for fir_interp. Three instances share the
// input side: A uses the default zero-order-hold coefficients, B a ramp
// COEFF[i]=i*1024, C a half-gain hold (COEFF[0..3]=0x200) whose outputs
// exercise floor rounding of negative products.
module tb_fir_interp;

    function automatic logic [0:31][31:0] ramp_coeffs();
        logic [0:31][31:0] r;
        for (int i = 0; i < 32; i++) r[i] = 32'(i * 1024);
        return r;
    endfunction

    localparam logic [0:31][31:0] RAMP = ramp_coeffs();
    localparam logic [0:31][31:0] HALF = {{4{32'h00000200}}, {28*32{1'b0}}};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] x_in = '0;
    logic        x_empty = 1'b1;
    logic        y_out_full = 1'b0;

    logic        x_rd_en_a, x_rd_en_b, x_rd_en_c;
    logic [31:0] y_out_a, y_out_b, y_out_c;
    logic        y_wr_en_a, y_wr_en_b, y_wr_en_c;

    fir_interp dut_a (
        .clock(clock), .reset(reset), .x_in(x_in), .x_rd_en(x_rd_en_a),
        .x_empty(x_empty), .y_out(y_out_a), .y_out_full(y_out_full), .y_wr_en(y_wr_en_a)
    );

    fir_interp #(.DATA_WIDTH(32), .TAPS(32), .INTERP(4), .BITS(10), .COEFF(RAMP)) dut_b (
        .clock(clock), .reset(reset), .x_in(x_in), .x_rd_en(x_rd_en_b),
        .x_empty(x_empty), .y_out(y_out_b), .y_out_full(y_out_full), .y_wr_en(y_wr_en_b)
    );

    fir_interp #(.DATA_WIDTH(32), .TAPS(32), .INTERP(4), .BITS(10), .COEFF(HALF)) dut_c (
        .clock(clock), .reset(reset), .x_in(x_in), .x_rd_en(x_rd_en_c),
        .x_empty(x_empty), .y_out(y_out_c), .y_out_full(y_out_full), .y_wr_en(y_wr_en_c)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wr_a[$], wr_b[$], wr_c[$];
    int          wr_cyc[$], rd_cyc[$];
    int          rd_b_cnt = 0, rd_c_cnt = 0;

    // Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
    always @(negedge clock) begin
        if (y_wr_en_a) begin
            wr_a.push_back(y_out_a);
            wr_cyc.push_back(cyc);
        end
        if (y_wr_en_b) wr_b.push_back(y_out_b);
        if (y_wr_en_c) wr_c.push_back(y_out_c);
        if (x_rd_en_a) rd_cyc.push_back(cyc);
        if (x_rd_en_b) rd_b_cnt++;
        if (x_rd_en_c) rd_c_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_log();
        wr_a.delete(); wr_b.delete(); wr_c.delete();
        wr_cyc.delete(); rd_cyc.delete();
        rd_b_cnt = 0; rd_c_cnt = 0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Present one sample and hold it until the DUT pops it.
    task automatic send(input logic [31:0] v);
        int n = 0;
        x_in    = v;
        x_empty = 1'b0;
        @(negedge clock);
        while (!x_rd_en_a && n < 200) begin
            @(posedge clock);
            #1;
            @(negedge clock);
            n++;
        end
        check_eq("pop_timeout", 32'(n < 200), 32'd1);
        @(posedge clock);
        #1 x_empty = 1'b1;
    endtask

    task automatic wait_writes(input int n);
        int t = 0;
        while (wr_a.size() < n && t < 2000) begin
            @(posedge clock);
            t++;
        end
        #1;
        check_eq("write_count", 32'(wr_a.size()), 32'(n));
    endtask

    int exp_cyc2[4]   = '{10, 19, 28, 37};
    int exp_cyc4[4]   = '{10, 24, 33, 42};
    logic [31:0] exp_b2[8] = '{32'd0, 32'd5, 32'd10, 32'd15, 32'd20, 32'd22, 32'd24, 32'd26};
    logic [31:0] exp_c2[8] = '{32'd2, 32'd2, 32'd2, 32'd2,
                               32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE};

    initial begin
        int rd0;
        int c0;
        int t;

        // 1: reset holds everything quiet, even with the input FIFO non-empty
        for (int i = 0; i < 20; i++) begin
            if (i == 10) x_empty = 1'b0;
            @(negedge clock);
            check_eq("rst_y_out", y_out_a, 32'd0);
            check_eq("rst_y_wr_en", 32'(y_wr_en_a), 32'd0);
            check_eq("rst_x_rd_en", 32'(x_rd_en_a), 32'd0);
            @(posedge clock);
            #1;
        end
        x_empty = 1'b1;
        reset   = 1'b0;
        @(posedge clock);
        #1;

        // 2: 5 then -3, default hold, timing of writes and second pop
        clear_log();
        send(32'd5);
        send(32'hFFFFFFFD);
        wait_writes(8);
        check_eq("t2_pops", 32'(rd_cyc.size()), 32'd2);
        rd0 = rd_cyc[0];
        check_eq("t2_second_pop", 32'(rd_cyc[1] - rd0), 32'd37);
        for (int i = 0; i < 8; i++) begin
            check_eq("t2_y_hold", wr_a[i], (i < 4) ? 32'd5 : 32'hFFFFFFFD);
            check_eq("t2_y_ramp", wr_b[i], exp_b2[i]);
            check_eq("t2_y_half", wr_c[i], exp_c2[i]);
        end
        for (int i = 0; i < 4; i++) check_eq("t2_wr_cycle", 32'(wr_cyc[i] - rd0), 32'(exp_cyc2[i]));
        check_eq("t2_wr_cycle_next", 32'(wr_cyc[4] - rd0), 32'd47);

        // 3: impulse through ramp coefficients yields 0..31
        do_reset(2);
        clear_log();
        send(32'd1);
        for (int i = 0; i < 7; i++) send(32'd0);
        wait_writes(32);
        for (int i = 0; i < 32; i++) begin
            check_eq("t3_y_ramp", wr_b[i], 32'(i));
            check_eq("t3_y_hold", wr_a[i], (i < 4) ? 32'd1 : 32'd0);
        end

        // 4: output FIFO full for 5 cycles at phase-1 write
        do_reset(2);
        clear_log();
        fork
            begin
                send(32'd7);
                send(32'd9);
            end
            begin
                t = 0;
                while (rd_cyc.size() == 0 && t < 200) begin
                    @(posedge clock);
                    t++;
                end
                #1;
                if (rd_cyc.size() != 0) begin
                    c0 = rd_cyc[0];
                    while (cyc < c0 + 18) begin
                        @(posedge clock);
                        #1;
                    end
                    y_out_full = 1'b1;
                    repeat (5) begin
                        @(posedge clock);
                        #1;
                    end
                    y_out_full = 1'b0;
                end
            end
        join
        wait_writes(8);
        rd0 = rd_cyc[0];
        for (int i = 0; i < 4; i++) check_eq("t4_wr_cycle", 32'(wr_cyc[i] - rd0), 32'(exp_cyc4[i]));
        check_eq("t4_second_pop", 32'(rd_cyc[1] - rd0), 32'd42);
        for (int i = 0; i < 8; i++) check_eq("t4_y", wr_a[i], (i < 4) ? 32'd7 : 32'd9);

        // 5: input FIFO empty for 50 cycles after the phase-3 write
        repeat (50) @(posedge clock);
        #1;
        check_eq("t5_idle_writes", 32'(wr_a.size()), 32'd8);
        check_eq("t5_idle_pops", 32'(rd_cyc.size()), 32'd2);
        c0 = cyc;
        send(32'd11);
        wait_writes(12);
        check_eq("t5_pop_same_cycle", 32'(rd_cyc[2]), 32'(c0));
        check_eq("t5_first_write", 32'(wr_cyc[8] - rd_cyc[2]), 32'd10);
        check_eq("t5_y", wr_a[8], 32'd11);

        // 6: reset during MAC discards sample 9 and its history
        do_reset(2);
        clear_log();
        send(32'd9);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        send(32'd1);
        for (int i = 0; i < 7; i++) send(32'd0);
        wait_writes(32);
        repeat (20) @(posedge clock);
        #1;
        check_eq("t6_total_writes", 32'(wr_b.size()), 32'd32);
        check_eq("t6_pops", 32'(rd_cyc.size()), 32'd9);
        check_eq("t6_pops_b", 32'(rd_b_cnt), 32'd9);
        check_eq("t6_pops_c", 32'(rd_c_cnt), 32'd9);
        for (int i = 0; i < 32; i++) check_eq("t6_y_ramp", wr_b[i], 32'(i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fir_interp.md
Name: fir_interp

Overview:
- Polyphase interpolating FIR for the FM receive chain, the upsampling counterpart of the decimating FIR.
- Reads one sample from an upstream FIFO and writes INTERP filtered samples to a downstream FIFO.
- Used where a stage must raise the sample rate, for example audio output rate conversion.
- Fixed-point Q(BITS) coefficients, one multiply-accumulate per clock.

Parameters:
- DATA_WIDTH, 32: sample, coefficient and accumulator width.
- TAPS, 32: total filter length. TAPS must be a multiple of INTERP.
- INTERP, 4: interpolation factor, i.e. outputs per input.
- BITS, 10: dequantization shift applied to each product.
- COEFF, [0:TAPS-1][DATA_WIDTH-1:0]: Q(BITS) coefficients. Default is COEFF[0..3]=32'h00000400 and all others 0, which gives a zero-order hold.

Ports:
- clock, input, 1: sole clock. All state changes on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- x_in, input, DATA_WIDTH: signed input sample from the FIFO head.
- x_rd_en, output, 1: combinational pop strobe to the input FIFO.
- x_empty, input, 1: input FIFO empty.
- y_out, output, DATA_WIDTH: registered signed output sample.
- y_out_full, input, 1: output FIFO full.
- y_wr_en, output, 1: registered push strobe to the output FIFO.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - While reset is high at a rising edge: state goes to S_READ; shift register, accumulator, phase and k go to 0; y_out=0; y_wr_en=0. x_rd_en=0 during reset.
  - Reset mid-operation discards the in-flight sample, the partial sum and all history.
- Storage: shift register x[0..M-1], M=TAPS/INTERP, with x[0] the newest sample.
- Output equation: for phase p in 0..INTERP-1, y_p = sum over k=0..M-1 of deq(COEFF[k*INTERP+p] * x[k]).
  - deq(v): full 2*DATA_WIDTH signed product, arithmetic right shift by BITS, truncate to DATA_WIDTH. Rounds toward negative infinity.
  - Accumulate modulo 2^DATA_WIDTH (wraps, no saturation). No bias is added.
- S_READ:
  - If x_empty=0: x_rd_en=1 in the same cycle, x_in shifts into x[0], x[i] takes x[i-1], phase=0, k=0, sum=0, go to S_MAC.
  - If x_empty=1: x_rd_en=0 and stay in S_READ.
- S_MAC:
  - Each cycle: sum += deq(COEFF[k*INTERP+phase]*x[k]), then k++.
  - After the k=M-1 term, go to S_WRITE.
  - Takes exactly M cycles and is never stalled.
- S_WRITE:
  - If y_out_full=0: y_out<=sum and y_wr_en<=1, both visible the next cycle.
    - If phase==INTERP-1, go to S_READ.
    - Otherwise phase++, k=0, sum=0, go to S_MAC.
  - If y_out_full=1: hold state, sum and phase, and write nothing.
- Strobe and output rules:
  - y_wr_en is high for exactly one cycle per accepted write.
  - y_out holds its last written value while y_wr_en=0.
- Throughput and latency (no stalls):
  - First x_rd_en at cycle 0.
  - MAC on cycles 1..8; S_WRITE on cycle 9; y_wr_en on cycle 10.
  - Subsequent phases produce y_wr_en on cycles 19, 28 and 37.
  - Next possible x_rd_en is cycle 37 (S_READ is re-entered after the cycle-36 write).
  - Period per input = INTERP*(M+1)+1 = 37 cycles.
- Handshake rules:
  - x_rd_en is asserted only in S_READ, so samples are never popped while outputs are pending.
  - There is no pop-write overlap.

Test Plan:
1. Reset with x_empty=1, y_out_full=0 for 20 cycles -> y_out=0, y_wr_en=0, x_rd_en=0 throughout.
2. Default COEFF; inputs 5 then 32'hFFFFFFFD -> outputs 5,5,5,5,FFFFFFFD x4. y_wr_en at cycles 10,19,28,37 after the first x_rd_en. Second x_rd_en at cycle 37.
3. COEFF[i]=i*1024; inputs 1 followed by seven 0s -> 32 outputs 0,1,2,...,31 in order.
4. Default COEFF; hold y_out_full=1 for 5 cycles on reaching S_WRITE of phase 1 -> no y_wr_en and no x_rd_en during the stall. After release, exactly one write of the correct value; total output count is still 4 per input.
5. x_empty=1 after the phase-3 write for 50 cycles -> x_rd_en and y_wr_en stay 0. Deassert x_empty -> x_rd_en in the same cycle, and y_wr_en 10 cycles later.
6. COEFF[i]=i*1024; feed 9, assert reset for 1 cycle during S_MAC, then feed 1 and seven 0s -> outputs 0..31 exactly, with no residue from 9.
